// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL sequencer.
// Optional relock-on-loss behaviour is selected by PLL_CTRL_RELOCK_EN (see pll_ctrl).
package pll_ctrl_pkg;

   localparam int unsigned FBDIV_W        = 8;
   localparam int unsigned LOSS_W         = 8;
   localparam int unsigned DEF_SETTLE     = 4;
   localparam int unsigned DEF_STABLE     = 16;
   localparam int unsigned DEF_TIMEOUT    = 4096;
   localparam int unsigned DEF_MAX_RETRY  = 3;

   typedef enum logic [2:0] {
      OFF,
      PROGRAM,
      START,
      WAIT_LOCK,
      LOCKED,
      FAULT
   } pll_ctrl_state_e;

   function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
      return (v == {LOSS_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pll_lock_qual.sv
// Lock qualifier: 2-flop synchronizer on the asynchronous PLL lock flag followed by a
// consecutive-high filter; lock_ok asserts on the cycle the run reaches LOCK_STABLE_CYC.
module pll_lock_qual #(
   parameter int unsigned LOCK_STABLE_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic lock_in,
   output logic lock_s,
   output logic lock_ok
);

   localparam int unsigned CW = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
   localparam logic [CW-1:0] CMAX = CW'((LOCK_STABLE_CYC > 0) ? LOCK_STABLE_CYC - 1 : 0);

   logic          meta_q;
   logic          sync_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= lock_in;
         sync_q <= meta_q;
         if (clr || !sync_q) begin
            cnt_q <= '0;
         end else if (cnt_q != CMAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign lock_s  = sync_q;
   // cnt_q counts highs already seen, so this cycle's high completes the run.
   assign lock_ok = sync_q && (cnt_q == CMAX);

endmodule

// File: rtl/pll_ctrl.sv
// PLL power-up sequencer: divider handshake, settle, lock qualification, retry and loss count.
// Define PLL_CTRL_RELOCK_EN to fully re-program the PLL on lock loss instead of re-waiting.
module pll_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned          SETTLE_CYC      = DEF_SETTLE,
   parameter int unsigned          LOCK_STABLE_CYC = DEF_STABLE,
   parameter int unsigned          LOCK_TIMEOUT    = DEF_TIMEOUT,
   parameter int unsigned          MAX_RETRY       = DEF_MAX_RETRY,
   parameter logic [FBDIV_W-1:0]   FBDIV_RESET     = 8'd1
) (
   input  logic               rclk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [FBDIV_W-1:0] cfg_fbdiv,
   output logic               pll_en,
   output logic [FBDIV_W-1:0] pll_fbdiv,
   input  logic               pll_lock,
   output logic               locked,
   output logic               fault,
   output logic [LOSS_W-1:0]  loss_cnt
);

   localparam int unsigned SW = $clog2(SETTLE_CYC + 2);
   localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam int unsigned RW = $clog2(MAX_RETRY + 2);

   localparam logic [SW-1:0] SETTLE_LOAD = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [TW-1:0] TMO_MAX     = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

   pll_ctrl_state_e state_q;
   logic [SW-1:0]   settle_q;
   logic [TW-1:0]   tmo_q;
   logic [RW-1:0]   retry_q;

   logic lock_s;
   logic lock_ok;
   logic qual_clr;
   logic accept;
   logic loss;

   pll_lock_qual #(
      .LOCK_STABLE_CYC (LOCK_STABLE_CYC)
   ) u_lock_qual (
      .clk     (rclk),
      .rst     (rst),
      .clr     (qual_clr),
      .lock_in (pll_lock),
      .lock_s  (lock_s),
      .lock_ok (lock_ok)
   );

   assign cfg_ready = (state_q == OFF) || (state_q == LOCKED) || (state_q == FAULT);
   assign accept    = cfg_valid && cfg_ready;
   assign loss      = (state_q == LOCKED) && !lock_s;
   assign qual_clr  = (state_q == START);

   always_ff @(posedge rclk) begin
      if (rst) begin
         state_q   <= OFF;
         pll_en    <= 1'b0;
         pll_fbdiv <= FBDIV_RESET;
         locked    <= 1'b0;
         fault     <= 1'b0;
         loss_cnt  <= '0;
         settle_q  <= '0;
         tmo_q     <= '0;
         retry_q   <= '0;
      end else begin
         // A loss is counted even when a same-cycle request overrides the reaction.
         if (loss) begin
            loss_cnt <= sat_inc(loss_cnt);
         end

         if (accept) begin
            pll_en <= 1'b0;
            locked <= 1'b0;
            fault  <= 1'b0;
            if (cfg_fbdiv == '0) begin
               state_q <= OFF;
            end else begin
               pll_fbdiv <= cfg_fbdiv;
               retry_q   <= '0;
               settle_q  <= SETTLE_LOAD;
               state_q   <= PROGRAM;
            end
         end else begin
            case (state_q)
               OFF, FAULT: begin
                  pll_en <= 1'b0;
               end

               PROGRAM: begin
                  if (settle_q == '0) begin
                     pll_en  <= 1'b1;
                     state_q <= START;
                  end else begin
                     settle_q <= settle_q - 1'b1;
                  end
               end

               START: begin
                  tmo_q   <= '0;
                  state_q <= WAIT_LOCK;
               end

               WAIT_LOCK: begin
                  if (lock_ok) begin
                     locked  <= 1'b1;
                     state_q <= LOCKED;
                  end else if (tmo_q == TMO_MAX) begin
                     pll_en <= 1'b0;
                     if (retry_q < RETRY_MAX) begin
                        retry_q  <= retry_q + 1'b1;
                        settle_q <= SETTLE_LOAD;
                        state_q  <= PROGRAM;
                     end else begin
                        fault   <= 1'b1;
                        state_q <= FAULT;
                     end
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end

               LOCKED: begin
                  if (!lock_s) begin
                     locked <= 1'b0;
`ifdef PLL_CTRL_RELOCK_EN
                     // Relock holds EN low one cycle longer than a fresh program.
                     pll_en   <= 1'b0;
                     retry_q  <= '0;
                     settle_q <= SW'(SETTLE_CYC);
                     state_q  <= PROGRAM;
`else
                     tmo_q   <= '0;
                     state_q <= WAIT_LOCK;
`endif
                  end
               end

               default: begin
                  pll_en  <= 1'b0;
                  state_q <= OFF;
               end
            endcase
         end
      end
   end

endmodule
